// File: rtl/final_frame_writer_pkg.sv
// Shared types and helpers for the final-frame write path.
// Block-index map, FSM encoding and pixel-row extraction.
package final_frame_writer_pkg;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_CALC  = 2'd1,
    S_WRITE = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  localparam logic [4:0] LUMA_LAST = 5'd15;
  localparam logic [4:0] CB_FIRST  = 5'd16;
  localparam logic [4:0] CR_FIRST  = 5'd20;
  localparam logic [4:0] IDX_MAX   = 5'd23;

  // Row r of a 4x4 block packed as column 0 in [7:0]
  function automatic logic [31:0] pix_row(
    input logic [127:0] pix,
    input logic [1:0]   row
  );
    return pix[{row, 5'b0} +: 32];
  endfunction

endpackage

// File: rtl/frame_wr_addr_gen.sv
// Base word address and row stride of a 4x4 block
// in the final-frame luma/chroma RAMs.
module frame_wr_addr_gen
  import final_frame_writer_pkg::*;
(
  input  logic [4:0]  idx,
  input  logic [7:0]  mb_h,
  input  logic [7:0]  mb_v,
  input  logic [7:0]  pic_w_m1,
  input  logic [7:0]  pic_h_m1,
  output logic [19:0] base,
  output logic [19:0] stride,
  output logic        is_chroma,
  output logic        illegal
);

  logic [31:0] w, h, mbh, mbv;
  logic [31:0] x, y, strd, cr_off;

  always_comb begin
    w      = 32'(pic_w_m1) + 32'd1;
    h      = 32'(pic_h_m1) + 32'd1;
    mbh    = 32'(mb_h);
    mbv    = 32'(mb_v);
    x      = '0;
    y      = '0;
    strd   = '0;
    cr_off = '0;
    base   = '0;
    stride = '0;
    is_chroma = (idx >= CB_FIRST);
    illegal = (idx > IDX_MAX) || (mb_h > pic_w_m1)
           || (mb_v > pic_h_m1);
    if (!is_chroma) begin
      x      = 32'(idx[2]) * 32'd8 + 32'(idx[0]) * 32'd4;
      y      = 32'(idx[3]) * 32'd8 + 32'(idx[1]) * 32'd4;
      strd   = w * 32'd4;
      base   = 20'((mbv * 32'd16 + y) * strd
             + mbh * 32'd4 + x / 32'd4);
      stride = 20'(strd);
    end else begin
      // Cb and Cr planes follow luma; Cr sits one Cb plane further
      x      = 32'(idx[0]) * 32'd4;
      y      = 32'(idx[1]) * 32'd4;
      strd   = w * 32'd2;
      cr_off = (idx >= CR_FIRST) ? strd * h * 32'd8 : 32'd0;
      base   = 20'((mbv * 32'd8 + y) * strd
             + mbh * 32'd2 + x / 32'd4 + cr_off);
      stride = 20'(strd);
    end
  end

endmodule

// File: rtl/final_frame_writer.sv
// Writes reconstructed 4x4 blocks into the final-frame
// luma/chroma RAMs as four row writes per block.
module final_frame_writer
  import final_frame_writer_pkg::*;
(
  input  logic         clk,
  input  logic         reset,
  input  logic         blk_valid,
  output logic         blk_ready,
  input  logic [4:0]   blk_idx,
  input  logic [127:0] blk_pix,
  input  logic [7:0]   mb_num_h,
  input  logic [7:0]   mb_num_v,
  input  logic [7:0]   pic_width_in_mbs_minus1,
  input  logic [7:0]   pic_height_in_map_units_minus1,
  output logic         final_frame_luma_wr,
  output logic [19:0]  final_frame_luma_wr_addr,
  output logic         final_frame_chroma_wr,
  output logic [18:0]  final_frame_chroma_wr_addr,
  output logic [31:0]  final_frame_RAM_din,
  output logic         blk_done,
  output logic         blk_err
);

  state_t       state_q;
  logic [4:0]   idx_q;
  logic [7:0]   mbh_q, mbv_q, pw_q, ph_q;
  logic [127:0] pix_q;
  logic [19:0]  stride_q;
  logic         chroma_q;
  logic [1:0]   row_q;

  logic [19:0]  base, stride;
  logic         is_chroma, illegal;

  frame_wr_addr_gen u_addr_gen (
    .idx       (idx_q),
    .mb_h      (mbh_q),
    .mb_v      (mbv_q),
    .pic_w_m1  (pw_q),
    .pic_h_m1  (ph_q),
    .base      (base),
    .stride    (stride),
    .is_chroma (is_chroma),
    .illegal   (illegal)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= S_IDLE;
      idx_q      <= '0;
      mbh_q      <= '0;
      mbv_q      <= '0;
      pw_q       <= '0;
      ph_q       <= '0;
      pix_q      <= '0;
      stride_q   <= '0;
      chroma_q   <= 1'b0;
      row_q      <= '0;
      blk_ready  <= 1'b1;
      blk_done   <= 1'b0;
      blk_err    <= 1'b0;
      final_frame_luma_wr        <= 1'b0;
      final_frame_luma_wr_addr   <= '0;
      final_frame_chroma_wr      <= 1'b0;
      final_frame_chroma_wr_addr <= '0;
      final_frame_RAM_din        <= '0;
    end else begin
      final_frame_luma_wr   <= 1'b0;
      final_frame_chroma_wr <= 1'b0;
      blk_done <= 1'b0;
      blk_err  <= 1'b0;
      unique case (state_q)
        S_IDLE: begin
          if (blk_valid) begin
            idx_q     <= blk_idx;
            mbh_q     <= mb_num_h;
            mbv_q     <= mb_num_v;
            pw_q      <= pic_width_in_mbs_minus1;
            ph_q      <= pic_height_in_map_units_minus1;
            pix_q     <= blk_pix;
            blk_ready <= 1'b0;
            state_q   <= S_CALC;
          end
        end
        S_CALC: begin
          if (illegal) begin
            blk_done <= 1'b1;
            blk_err  <= 1'b1;
            state_q  <= S_DONE;
          end else begin
            // Row 0 goes out directly from the computed base
            stride_q <= stride;
            chroma_q <= is_chroma;
            row_q    <= 2'd0;
            if (is_chroma) begin
              final_frame_chroma_wr      <= 1'b1;
              final_frame_chroma_wr_addr <= base[18:0];
            end else begin
              final_frame_luma_wr      <= 1'b1;
              final_frame_luma_wr_addr <= base;
            end
            final_frame_RAM_din <= pix_row(pix_q, 2'd0);
            state_q <= S_WRITE;
          end
        end
        S_WRITE: begin
          if (row_q == 2'd3) begin
            blk_done <= 1'b1;
            state_q  <= S_DONE;
          end else begin
            row_q <= 2'(row_q + 2'd1);
            if (chroma_q) begin
              final_frame_chroma_wr      <= 1'b1;
              final_frame_chroma_wr_addr <=
                final_frame_chroma_wr_addr + stride_q[18:0];
            end else begin
              final_frame_luma_wr      <= 1'b1;
              final_frame_luma_wr_addr <=
                final_frame_luma_wr_addr + stride_q;
            end
            final_frame_RAM_din <=
              pix_row(pix_q, 2'(row_q + 2'd1));
          end
        end
        S_DONE: begin
          blk_ready <= 1'b1;
          state_q   <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_final_frame_writer.sv
// Directed self-checking bench for final_frame_writer.
// QCIF picture (11x9 MBs) throughout.
module tb_final_frame_writer;

  logic         clk = 1'b0;
  logic         reset;
  logic         blk_valid;
  logic         blk_ready;
  logic [4:0]   blk_idx;
  logic [127:0] blk_pix;
  logic [7:0]   mb_num_h, mb_num_v;
  logic [7:0]   pic_w_m1, pic_h_m1;
  logic         luma_wr, chroma_wr;
  logic [19:0]  luma_addr;
  logic [18:0]  chroma_addr;
  logic [31:0]  din;
  logic         blk_done, blk_err;

  final_frame_writer dut (
    .clk                            (clk),
    .reset                          (reset),
    .blk_valid                      (blk_valid),
    .blk_ready                      (blk_ready),
    .blk_idx                        (blk_idx),
    .blk_pix                        (blk_pix),
    .mb_num_h                       (mb_num_h),
    .mb_num_v                       (mb_num_v),
    .pic_width_in_mbs_minus1        (pic_w_m1),
    .pic_height_in_map_units_minus1 (pic_h_m1),
    .final_frame_luma_wr            (luma_wr),
    .final_frame_luma_wr_addr       (luma_addr),
    .final_frame_chroma_wr          (chroma_wr),
    .final_frame_chroma_wr_addr     (chroma_addr),
    .final_frame_RAM_din            (din),
    .blk_done                       (blk_done),
    .blk_err                        (blk_err)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;

  int          a_edge[$];
  int          w_edge[$];
  int          w_kind[$];
  logic [31:0] w_addr[$];
  logic [31:0] w_din[$];
  int          d_edge[$];
  logic        d_err[$];

  task automatic check(input string tag,
                       input logic [31:0] obs,
                       input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (!reset && blk_valid && blk_ready)
      a_edge.push_back(cyc + 1);
  end

  always @(negedge clk) begin
    if (!reset) begin
      if (luma_wr || chroma_wr) begin
        check("excl", {31'b0, luma_wr & chroma_wr}, 32'd0);
        w_edge.push_back(cyc);
        w_kind.push_back(luma_wr ? 1 : 2);
        w_addr.push_back(luma_wr ? 32'(luma_addr)
                                 : 32'(chroma_addr));
        w_din.push_back(din);
      end
      if (blk_done) begin
        d_edge.push_back(cyc);
        d_err.push_back(blk_err);
      end
    end
  end

  function automatic logic [127:0] mkpix(input logic [7:0] s);
    logic [127:0] p;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        p[(r*4+c)*8 +: 8] = s + 8'(r*16 + c);
    return p;
  endfunction

  function automatic logic [31:0] exp_row(input logic [7:0] s,
                                          input int r);
    logic [7:0] b;
    b = s + 8'(r*16);
    return {b + 8'd3, b + 8'd2, b + 8'd1, b};
  endfunction

  task automatic clear_logs();
    a_edge.delete(); w_edge.delete(); w_kind.delete();
    w_addr.delete(); w_din.delete();
    d_edge.delete(); d_err.delete();
  endtask

  task automatic drive(input logic [4:0] idx,
                       input logic [7:0] h, input logic [7:0] v,
                       input logic [7:0] s);
    blk_idx  = idx;
    mb_num_h = h;
    mb_num_v = v;
    blk_pix  = mkpix(s);
  endtask

  task automatic send_one(input logic [4:0] idx,
                          input logic [7:0] h, input logic [7:0] v,
                          input logic [7:0] s, output int t);
    int n0;
    n0 = a_edge.size();
    t = -100;
    @(negedge clk); #2;
    drive(idx, h, v, s);
    blk_valid = 1'b1;
    for (int i = 0; i < 20 && a_edge.size() == n0; i++) begin
      @(posedge clk); #1;
    end
    if (a_edge.size() == n0)
      check("accept_timeout", 32'd0, 32'd1);
    else
      t = a_edge[$];
    @(negedge clk); #2;
    blk_valid = 1'b0;
    blk_idx   = 5'd3;
    mb_num_h  = 8'd7;
    mb_num_v  = 8'd5;
    blk_pix   = {4{32'hDEADBEEF}};
  endtask

  task automatic run_blk(input string tag, input logic [4:0] idx,
                         input logic [7:0] h, input logic [7:0] v,
                         input logic [7:0] s,
                         input logic [31:0] base,
                         input logic [31:0] stride,
                         input bit chroma, input bit err);
    int t;
    clear_logs();
    send_one(idx, h, v, s, t);
    for (int i = 0; i < 20 && d_edge.size() == 0; i++) begin
      @(negedge clk); #1;
    end
    if (d_edge.size() == 0) begin
      check({tag, ".done_timeout"}, 32'd0, 32'd1);
      return;
    end
    check({tag, ".done_edge"}, 32'(d_edge[0] - t), err ? 1 : 5);
    check({tag, ".err"}, {31'b0, d_err[0]}, {31'b0, err});
    check({tag, ".nwr"}, 32'(w_edge.size()), err ? 0 : 4);
    for (int r = 0; r < 4 && r < w_edge.size(); r++) begin
      check($sformatf("%s.addr%0d", tag, r), w_addr[r],
            base + 32'(r) * stride);
      check($sformatf("%s.din%0d", tag, r), w_din[r],
            exp_row(s, r));
      check($sformatf("%s.kind%0d", tag, r), 32'(w_kind[r]),
            chroma ? 2 : 1);
      check($sformatf("%s.wedge%0d", tag, r),
            32'(w_edge[r] - t), 32'(r + 1));
    end
    @(negedge clk); #1;
    check({tag, ".ready"}, {31'b0, blk_ready}, 32'd1);
  endtask

  task automatic b2b_test();
    logic [4:0]  ix[3] = '{5'd0, 5'd5, 5'd23};
    logic [7:0]  hh[3] = '{8'd0, 8'd2, 8'd0};
    logic [7:0]  vv[3] = '{8'd0, 8'd1, 8'd0};
    logic [7:0]  ss[3] = '{8'h10, 8'h20, 8'h30};
    logic [31:0] bb[3] = '{32'd0, 32'd715, 32'd1673};
    logic [31:0] st[3] = '{32'd44, 32'd44, 32'd22};
    int ok;
    ok = 1;
    clear_logs();
    @(negedge clk); #2;
    drive(ix[0], hh[0], vv[0], ss[0]);
    blk_valid = 1'b1;
    for (int b = 0; b < 3 && ok == 1; b++) begin
      for (int i = 0; i < 20 && a_edge.size() <= b; i++) begin
        @(posedge clk); #1;
      end
      if (a_edge.size() <= b) begin
        check("b2b.accept_timeout", 32'd0, 32'd1);
        ok = 0;
      end else if (b < 2) begin
        drive(ix[b+1], hh[b+1], vv[b+1], ss[b+1]);
      end
    end
    blk_valid = 1'b0;
    if (ok == 0) return;
    for (int i = 0; i < 30 && d_edge.size() < 3; i++) begin
      @(negedge clk); #1;
    end
    repeat (3) @(negedge clk);
    check("b2b.nacc", 32'(a_edge.size()), 32'd3);
    check("b2b.acc1", 32'(a_edge[1] - a_edge[0]), 32'd7);
    check("b2b.acc2", 32'(a_edge[2] - a_edge[0]), 32'd14);
    check("b2b.ndone", 32'(d_edge.size()), 32'd3);
    check("b2b.nwr", 32'(w_edge.size()), 32'd12);
    for (int k = 0; k < 12 && k < w_edge.size(); k++) begin
      check($sformatf("b2b.addr%0d", k), w_addr[k],
            bb[k/4] + 32'(k%4) * st[k/4]);
      check($sformatf("b2b.din%0d", k), w_din[k],
            exp_row(ss[k/4], k%4));
    end
  endtask

  task automatic reset_test();
    int t;
    clear_logs();
    send_one(5'd0, 8'd0, 8'd0, 8'h55, t);
    for (int i = 0; i < 20 && w_edge.size() < 2; i++) begin
      @(negedge clk); #1;
    end
    check("rst.reach_row1", 32'(w_edge.size()), 32'd2);
    reset = 1'b1;
    #1;
    check("rst.luma_wr", {31'b0, luma_wr}, 32'd0);
    check("rst.luma_addr", 32'(luma_addr), 32'd0);
    check("rst.din", din, 32'd0);
    check("rst.ready", {31'b0, blk_ready}, 32'd1);
    @(negedge clk); #2;
    reset = 1'b0;
    repeat (10) @(negedge clk);
    #1;
    check("rst.no_done", 32'(d_edge.size()), 32'd0);
    check("rst.no_more_wr", 32'(w_edge.size()), 32'd2);
    run_blk("post_rst", 5'd0, 8'd1, 8'd0, 8'h60, 32'd4, 32'd44,
            1'b0, 1'b0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset     = 1'b1;
    blk_valid = 1'b0;
    blk_idx   = '0;
    blk_pix   = '0;
    mb_num_h  = '0;
    mb_num_v  = '0;
    pic_w_m1  = 8'd10;
    pic_h_m1  = 8'd8;
    repeat (3) @(negedge clk);
    check("rst0.ready", {31'b0, blk_ready}, 32'd1);
    check("rst0.luma_wr", {31'b0, luma_wr}, 32'd0);
    check("rst0.chroma_wr", {31'b0, chroma_wr}, 32'd0);
    check("rst0.luma_addr", 32'(luma_addr), 32'd0);
    check("rst0.chroma_addr", 32'(chroma_addr), 32'd0);
    check("rst0.din", din, 32'd0);
    check("rst0.done", {31'b0, blk_done}, 32'd0);
    check("rst0.err", {31'b0, blk_err}, 32'd0);
    #2 reset = 1'b0;
    repeat (2) @(negedge clk);

    run_blk("l0", 5'd0, 8'd0, 8'd0, 8'h00, 32'd0, 32'd44,
            1'b0, 1'b0);
    run_blk("l5", 5'd5, 8'd2, 8'd1, 8'h40, 32'd715, 32'd44,
            1'b0, 1'b0);
    run_blk("cr23", 5'd23, 8'd0, 8'd0, 8'h80, 32'd1673, 32'd22,
            1'b1, 1'b0);
    run_blk("cb16", 5'd16, 8'd10, 8'd8, 8'hA0, 32'd1428, 32'd22,
            1'b1, 1'b0);
    run_blk("idx24", 5'd24, 8'd0, 8'd0, 8'h00, 32'd0, 32'd0,
            1'b0, 1'b1);
    run_blk("mbh11", 5'd0, 8'd11, 8'd0, 8'h00, 32'd0, 32'd0,
            1'b0, 1'b1);
    run_blk("mbv9", 5'd17, 8'd0, 8'd9, 8'h00, 32'd0, 32'd0,
            1'b0, 1'b1);
    b2b_test();
    reset_test();

    $display("Simulation finished: %0d checks, %0d errors",
             n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/final_frame_writer.md
# final_frame_writer

Writes reconstructed 4x4 blocks, prediction plus residual, into the final-frame luma and chroma RAMs. It is the write side of the same RAMs that the inter-prediction path reads from: 32-bit words, four pixels per word, word-addressed luma (20 bit) and chroma (19 bit) ports. One block (luma 0..15, Cb 16..19, Cr 20..23) is accepted per valid/ready handshake and stored as four row writes. A done pulse follows the fourth row.

## Interface
Parameters:
- none; widths are fixed to match the final-frame RAM ports.

Ports:
- clk  in  1  single clock; all state on rising edge
- reset  in  1  asynchronous, active-high reset
- blk_valid  in  1  block, index and coordinates are valid
- blk_ready  out  1  block can be accepted (IDLE only)
- blk_idx  in  5  0..15 luma4x4BlkIdx (H.264 scan), 16..19 Cb, 20..23 Cr
- blk_pix  in  128  pixel (r,c) at bits [(r*4+c)*8 +: 8]
- mb_num_h, mb_num_v  in  8 each  current MB column/row
- pic_width_in_mbs_minus1  in  8  picture width in MBs minus 1
- pic_height_in_map_units_minus1  in  8  picture height in MBs minus 1
- final_frame_luma_wr  out  1  luma write strobe
- final_frame_luma_wr_addr  out  20  luma word address
- final_frame_chroma_wr  out  1  chroma write strobe
- final_frame_chroma_wr_addr  out  19  chroma word address
- final_frame_RAM_din  out  32  row data; column 0 in [7:0], column 3 in [31:24]
- blk_done  out  1  one-cycle pulse after last row
- blk_err  out  1  qualifies blk_done; block rejected, nothing written

## Operation
- FSM states: IDLE, CALC, WRITE, DONE.
- IDLE: blk_ready=1. On blk_valid: latch all inputs, go to CALC.
- CALC: compute and register base address and stride, then go to WRITE. An illegal block goes directly to DONE with the error flag set.
  - Illegal block: blk_idx>23, mb_num_h>pic_width_in_mbs_minus1, or mb_num_v>pic_height_in_map_units_minus1.
- WRITE: row counter 0..3. Each cycle asserts exactly one strobe (luma if idx<16, else chroma), with addr = base + row*stride and din = row's 4 pixels. After row 3, go to DONE.
- DONE: blk_done=1 and blk_err=flag. Next state IDLE.
- Luma geometry: x = idx[2]*8 + idx[0]*4, y = idx[3]*8 + idx[1]*4.
  - stride = (pic_width_in_mbs_minus1+1)*4 words.
  - base = (mb_num_v*16+y)*stride + mb_num_h*4 + x/4.
- Chroma geometry: i = (idx-16)&3, x = i[0]*4, y = i[1]*4.
  - stride = (pic_width_in_mbs_minus1+1)*2 words.
  - base = (mb_num_v*8+y)*stride + mb_num_h*2 + x/4 + (idx>=20 ? stride*(pic_height_in_map_units_minus1+1)*8 : 0).
- Arithmetic is unsigned, computed at full width, and truncated to 20/19 bits at the output register.
- blk_pix is captured at acceptance. Later changes on the inputs have no effect on the block in flight.

## Timing
- Reset values: state IDLE, blk_ready=1, both strobes 0, both addresses 0, din 0, blk_done 0, blk_err 0.
- Acceptance at edge T (blk_valid & blk_ready): CALC in cycle T+1.
- Row writes occupy cycles T+2..T+5, with strobe, address and din valid in the same cycle.
- blk_done occupies T+6; IDLE with blk_ready=1 at T+7.
- Throughput: one block per 7 cycles.
- Illegal block: blk_done=blk_err=1 at T+2, no strobe ever asserted, IDLE at T+3.
- blk_valid held high through DONE is not accepted until IDLE. The following block is accepted at T+7, with no double acceptance.
- Strobes are mutually exclusive and each is high for exactly 4 cycles per legal block.
- Reset mid-WRITE: the outputs immediately return to their reset values. The partial block is not resumed and no blk_done is issued for it.

## Structure
- Shared package holds:
  - FSM state encoding (2 bit).
  - Block-index constants: LUMA_LAST=15, CB_FIRST=16, CR_FIRST=20, IDX_MAX=23.
  - Pixel-lane extraction function.
- Sub-module frame_wr_addr_gen: pure combinational function of the latched idx, MB coordinates and picture size. It outputs base, stride, is_chroma and illegal; the CALC register captures them.

## Test plan
- Setup for all scenarios: pic_width_in_mbs_minus1=10, pic_height_in_map_units_minus1=8 (176x144).
- Luma idx 0, MB(0,0), rows 0x03020100, 0x13121110, ... -> luma writes at addresses 0, 44, 88, 132 with matching din; blk_done at T+6, blk_err=0.
- Luma idx 5, MB(2,1) -> addresses 715, 759, 803, 847; chroma strobe never asserted.
- Cr idx 23, MB(0,0) -> chroma addresses 1673, 1695, 1717, 1739. Cb idx 16, MB(10,8) -> 1428, 1450, 1472, 1494.
- blk_idx=24, or mb_num_h=11 -> no strobes; blk_done=blk_err=1 at T+2; blk_ready back at T+3.
- Back-to-back: blk_valid held high for three blocks -> acceptances at T, T+7, T+14; 12 writes total, in order.
- Reset asserted at the second row write -> strobes drop in the same cycle, state IDLE; the next block writes correctly from row 0.
